// File: rtl/sa_skew_feeder_pkg.sv
// Shared types and constants for the systolic-array skew feeder.
// Holds the FSM state encoding, the array I/O latency and the config clamp rule.
package sa_skew_feeder_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_FEED  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // Cycles from the first skewed beat until the far-corner PE holds its final sum.
    function automatic int io_latency(input int n);
        return 3 * n - 2;
    endfunction

    // Out-of-range active-row/column requests fall back to the full array.
    function automatic int clamp_cfg(input int value, input int n);
        return (value == 0 || value > n) ? n : value;
    endfunction

endpackage

// File: rtl/sa_skew_feeder_skew_lane.sv
// One edge lane of the feeder: picks the element that belongs on this lane at
// the given step of the diagonal wavefront, or zero when outside it or masked.
module skew_lane
    import sa_skew_feeder_pkg::*;
#(
    parameter int N          = 4,
    parameter int WDATA      = 4,
    parameter int CFG_WIDTH  = $clog2(N) + 1,
    parameter int STEP_WIDTH = 4,
    parameter int LANE       = 1
) (
    input  logic [1:N][WDATA-1:0] elems,
    input  logic [STEP_WIDTH-1:0] step,
    input  logic [CFG_WIDTH-1:0]  cfg,
    input  logic                  en,
    output logic [WDATA-1:0]      value
);

    int   idx;
    logic lane_on;

    always_comb begin
        idx     = int'(step) - LANE + 2;
        lane_on = en && (LANE <= int'(cfg));
        value   = '0;
        for (int k = 1; k <= N; k++) begin
            if (lane_on && idx == k) begin
                value = elems[k];
            end
        end
    end

endmodule

// File: rtl/sa_skew_feeder.sv
// Buffers an NxN A/B operand pair, clears the array, then streams A rows west
// and B columns north with a one-cycle-per-lane skew and flags completion.
module sa_skew_feeder
    import sa_skew_feeder_pkg::*;
#(
    parameter int N         = 4,
    parameter int WDATA     = 4,
    parameter int CFG_WIDTH = $clog2(N) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    // Load handshake: a beat transfers on a rising edge where in_valid && in_ready.
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:N][WDATA-1:0] in_a_row,
    input  logic [1:N][WDATA-1:0] in_b_col,
    input  logic [CFG_WIDTH-1:0]  row_cfg_in,
    input  logic [CFG_WIDTH-1:0]  col_cfg_in,
    output logic                  sa_rst_n,
    output logic [CFG_WIDTH-1:0]  sa_row_cfg,
    output logic [CFG_WIDTH-1:0]  sa_col_cfg,
    output logic [1:N][WDATA-1:0] feed_W,
    output logic [1:N][WDATA-1:0] feed_N,
    output logic                  feed_active,
    output logic                  done,
    output state_e                fsm_state
);

    localparam int LAT        = io_latency(N);
    localparam int FEED_LAST  = 2 * N - 2;
    localparam int STEP_WIDTH = $clog2(LAT) + 1;

    state_e                  state_q, state_d;
    logic [STEP_WIDTH-1:0]   t_q, t_d;
    logic [CFG_WIDTH-1:0]    k_q;
    logic [1:N][WDATA-1:0]   a_mem [1:N];
    logic [1:N][WDATA-1:0]   b_mem [1:N];
    logic [WDATA-1:0]        west_d [1:N];
    logic [WDATA-1:0]        north_d [1:N];
    logic                    accept;
    logic                    feed_en;

    assign in_ready    = (state_q == ST_LOAD);
    assign accept      = in_valid && in_ready;
    assign feed_active = (state_q == ST_FEED) || (state_q == ST_DRAIN);
    assign done        = feed_active && (t_q == STEP_WIDTH'(LAT - 1));
    assign fsm_state   = state_q;
    assign feed_en     = (state_d == ST_FEED);

    // The step counter keeps running through DRAIN so the done test is one compare.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        case (state_q)
            ST_LOAD: begin
                if (accept && k_q == CFG_WIDTH'(N)) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_d = ST_FEED;
                t_d     = '0;
            end
            ST_FEED, ST_DRAIN: begin
                t_d = t_q + STEP_WIDTH'(1);
                if (t_q == STEP_WIDTH'(LAT - 1)) begin
                    state_d = ST_LOAD;
                    t_d     = '0;
                end else if (t_q == STEP_WIDTH'(FEED_LAST)) begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_LOAD;
                t_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_LOAD;
            t_q        <= '0;
            k_q        <= CFG_WIDTH'(1);
            sa_row_cfg <= CFG_WIDTH'(N);
            sa_col_cfg <= CFG_WIDTH'(N);
            sa_rst_n   <= 1'b0;
            feed_W     <= '0;
            feed_N     <= '0;
            for (int i = 1; i <= N; i++) begin
                a_mem[i] <= '0;
                b_mem[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            sa_rst_n <= (state_d != ST_CLEAR);
            if (accept) begin
                for (int i = 1; i <= N; i++) begin
                    if (k_q == CFG_WIDTH'(i)) begin
                        a_mem[i] <= in_a_row;
                        b_mem[i] <= in_b_col;
                    end
                end
                if (k_q == CFG_WIDTH'(1)) begin
                    sa_row_cfg <= CFG_WIDTH'(clamp_cfg(int'(row_cfg_in), N));
                    sa_col_cfg <= CFG_WIDTH'(clamp_cfg(int'(col_cfg_in), N));
                end
                k_q <= (k_q == CFG_WIDTH'(N)) ? CFG_WIDTH'(1) : k_q + CFG_WIDTH'(1);
            end
            // Lanes see the next step so the registered feed lines up with t_q.
            for (int i = 1; i <= N; i++) begin
                feed_W[i] <= west_d[i];
                feed_N[i] <= north_d[i];
            end
        end
    end

    for (genvar i = 1; i <= N; i++) begin : g_lane
        skew_lane #(
            .N(N), .WDATA(WDATA), .CFG_WIDTH(CFG_WIDTH),
            .STEP_WIDTH(STEP_WIDTH), .LANE(i)
        ) u_west (
            .elems(a_mem[i]),
            .step (t_d),
            .cfg  (sa_row_cfg),
            .en   (feed_en),
            .value(west_d[i])
        );
        skew_lane #(
            .N(N), .WDATA(WDATA), .CFG_WIDTH(CFG_WIDTH),
            .STEP_WIDTH(STEP_WIDTH), .LANE(i)
        ) u_north (
            .elems(b_mem[i]),
            .step (t_d),
            .cfg  (sa_col_cfg),
            .en   (feed_en),
            .value(north_d[i])
        );
    end

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Bench for sa_skew_feeder: random and directed operand loads, cycle-exact feed
// checks against the wavefront rule, and an output-stationary array product check.
module tb_sa_skew_feeder;
    import sa_skew_feeder_pkg::*;

    localparam int N   = 4;
    localparam int W   = 4;
    localparam int CW  = $clog2(N) + 1;
    localparam int LAT = 3 * N - 2;

    // ---------------- clock / reset / DUT ----------------
    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [1:N][W-1:0]   in_a_row;
    logic [1:N][W-1:0]   in_b_col;
    logic [CW-1:0]       row_cfg_in;
    logic [CW-1:0]       col_cfg_in;
    logic                sa_rst_n;
    logic [CW-1:0]       sa_row_cfg;
    logic [CW-1:0]       sa_col_cfg;
    logic [1:N][W-1:0]   feed_W;
    logic [1:N][W-1:0]   feed_N;
    logic                feed_active;
    logic                done;
    state_e              fsm_state;

    always #5 clk = ~clk;

    sa_skew_feeder #(.N(N), .WDATA(W), .CFG_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a_row(in_a_row), .in_b_col(in_b_col),
        .row_cfg_in(row_cfg_in), .col_cfg_in(col_cfg_in),
        .sa_rst_n(sa_rst_n), .sa_row_cfg(sa_row_cfg), .sa_col_cfg(sa_col_cfg),
        .feed_W(feed_W), .feed_N(feed_N),
        .feed_active(feed_active), .done(done), .fsm_state(fsm_state)
    );

    // ---------------- scoreboard / reference model ----------------
    int            n_cmp = 0;
    int            n_err = 0;
    logic [W-1:0]  exp_q[$];
    int            a_m [1:N][1:N];
    int            b_m [1:N][1:N];
    int            rcfg, ccfg;
    int            hist_w [0:LAT-1][1:N];
    int            hist_n [0:LAT-1][1:N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int tb_clamp(input int v);
        return (v == 0 || v > N) ? N : v;
    endfunction

    function automatic int gen_a(input int dmode, input int k, input int j);
        case (dmode)
            1:       return (k == j) ? 1 : 0;
            2:       return (k + j) % (1 << W);
            default: return int'($urandom_range(0, (1 << W) - 1));
        endcase
    endfunction

    function automatic int gen_b(input int dmode, input int i, input int k);
        case (dmode)
            1:       return (i == k) ? 1 : 0;
            2:       return (i * k) % (1 << W);
            default: return int'($urandom_range(0, (1 << W) - 1));
        endcase
    endfunction

    task automatic drive_junk();
        for (int j = 1; j <= N; j++) begin
            in_a_row[j] = W'($urandom_range(0, (1 << W) - 1));
            in_b_col[j] = W'($urandom_range(0, (1 << W) - 1));
        end
        row_cfg_in = CW'($urandom_range(0, (1 << CW) - 1));
        col_cfg_in = CW'($urandom_range(0, (1 << CW) - 1));
    endtask

    // ---------------- driver: load phase ----------------
    // vmode: 0 random valid, 1 toggling valid, 2 valid every cycle.
    // limit < N stops after that many beats and pulses reset.
    task automatic load_frame(input int vmode, input int dmode, input int cfg_r,
                              input int cfg_c, input int limit);
        int acc, cyc, vr, vc;
        bit drv, v;
        int va [1:N];
        int vb [1:N];
        acc = 0; cyc = 0; drv = 0; vr = 0; vc = 0;
        while (1) begin
            @(negedge clk);
            if (drv) begin
                acc++;
                for (int j = 1; j <= N; j++) begin
                    a_m[acc][j] = va[j];
                    b_m[j][acc] = vb[j];
                end
                if (acc == 1) begin
                    rcfg = tb_clamp(vr);
                    ccfg = tb_clamp(vc);
                end
            end
            if (acc == limit) break;
            if (cyc >= 200) begin
                check("load_timeout", acc, limit);
                break;
            end
            check("in_ready_load", in_ready, 1);
            check("state_load", fsm_state, ST_LOAD);
            check("done_load", done, 0);
            check("feed_active_load", feed_active, 0);
            case (vmode)
                1:       v = (cyc % 2 == 0);
                2:       v = 1'b1;
                default: v = 1'($urandom_range(0, 1));
            endcase
            cyc++;
            for (int j = 1; j <= N; j++) begin
                va[j] = v ? gen_a(dmode, acc + 1, j) : int'($urandom_range(0, (1 << W) - 1));
                vb[j] = v ? gen_b(dmode, j, acc + 1) : int'($urandom_range(0, (1 << W) - 1));
                in_a_row[j] = W'(va[j]);
                in_b_col[j] = W'(vb[j]);
            end
            vr = (acc == 0) ? cfg_r : int'($urandom_range(0, (1 << CW) - 1));
            vc = (acc == 0) ? cfg_c : int'($urandom_range(0, (1 << CW) - 1));
            row_cfg_in = CW'(vr);
            col_cfg_in = CW'(vc);
            in_valid   = v;
            drv        = v;
        end
        if (limit < N) begin
            rst = 1'b1;
            in_valid = 1'b0;
            @(negedge clk);
            check("sa_rst_n_midload_rst", sa_rst_n, 0);
            check("in_ready_midload_rst", in_ready, 1);
            rst = 1'b0;
        end
    endtask

    // ---------------- checker: clear / feed / drain ----------------
    task automatic feed_frame(input int abort_t);
        int ev, idx;
        check("state_clear", fsm_state, ST_CLEAR);
        check("sa_rst_n_clear", sa_rst_n, 0);
        check("in_ready_clear", in_ready, 0);
        check("feed_active_clear", feed_active, 0);
        check("done_clear", done, 0);
        check("sa_row_cfg", sa_row_cfg, rcfg);
        check("sa_col_cfg", sa_col_cfg, ccfg);
        // Hold valid with junk through the rest of the frame; none of it may load.
        in_valid = 1'b1;
        drive_junk();
        exp_q.delete();
        for (int t = 0; t < LAT; t++) begin
            for (int r = 1; r <= N; r++) begin
                idx = t - r + 2;
                ev = (t <= 2 * N - 2 && r <= rcfg && idx >= 1 && idx <= N) ? a_m[r][idx] : 0;
                exp_q.push_back(W'(ev));
            end
            for (int c = 1; c <= N; c++) begin
                idx = t - c + 2;
                ev = (t <= 2 * N - 2 && c <= ccfg && idx >= 1 && idx <= N) ? b_m[idx][c] : 0;
                exp_q.push_back(W'(ev));
            end
        end
        for (int t = 0; t < LAT; t++) begin
            @(negedge clk);
            check("feed_active_run", feed_active, 1);
            check("in_ready_run", in_ready, 0);
            check("sa_rst_n_run", sa_rst_n, 1);
            check("done_run", done, (t == LAT - 1));
            for (int r = 1; r <= N; r++) begin
                check($sformatf("feed_W[%0d]@t%0d", r, t), feed_W[r], exp_q.pop_front());
                hist_w[t][r] = int'(feed_W[r]);
            end
            for (int c = 1; c <= N; c++) begin
                check($sformatf("feed_N[%0d]@t%0d", c, t), feed_N[c], exp_q.pop_front());
                hist_n[t][c] = int'(feed_N[c]);
            end
            if (t == abort_t) begin
                rst = 1'b1;
                in_valid = 1'b0;
                @(negedge clk);
                check("state_after_rst", fsm_state, ST_LOAD);
                check("in_ready_after_rst", in_ready, 1);
                check("sa_rst_n_after_rst", sa_rst_n, 0);
                check("feed_W_after_rst", feed_W, 0);
                check("feed_N_after_rst", feed_N, 0);
                check("feed_active_after_rst", feed_active, 0);
                check("done_after_rst", done, 0);
                rst = 1'b0;
                @(negedge clk);
                check("done_post_rst", done, 0);
                check("sa_rst_n_post_rst", sa_rst_n, 1);
                exp_q.delete();
                return;
            end
            if (t == LAT - 1) in_valid = 1'b0;
        end
        @(negedge clk);
        check("state_back_load", fsm_state, ST_LOAD);
        check("in_ready_back_load", in_ready, 1);
        check("done_back_load", done, 0);
        check("feed_W_idle", feed_W, 0);
        check("feed_N_idle", feed_N, 0);
        // Output-stationary array: PE(r,c) sees west lane r delayed c-1, north lane c delayed r-1.
        for (int r = 1; r <= rcfg; r++) begin
            for (int c = 1; c <= ccfg; c++) begin
                int acc_dut, acc_ref, sw, sn;
                acc_dut = 0;
                acc_ref = 0;
                for (int s = 0; s < LAT; s++) begin
                    sw = s - (c - 1);
                    sn = s - (r - 1);
                    if (sw >= 0 && sn >= 0) acc_dut += hist_w[sw][r] * hist_n[sn][c];
                end
                for (int k = 1; k <= N; k++) acc_ref += a_m[r][k] * b_m[k][c];
                check($sformatf("product[%0d][%0d]", r, c),
                      acc_dut % (1 << (2 * W)), acc_ref % (1 << (2 * W)));
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_a_row = '0;
        in_b_col = '0;
        row_cfg_in = '0;
        col_cfg_in = '0;
        repeat (2) begin
            @(negedge clk);
            check("rst_state", fsm_state, ST_LOAD);
            check("rst_in_ready", in_ready, 1);
            check("rst_sa_rst_n", sa_rst_n, 0);
            check("rst_feed_W", feed_W, 0);
            check("rst_feed_N", feed_N, 0);
            check("rst_feed_active", feed_active, 0);
            check("rst_done", done, 0);
            check("rst_row_cfg", sa_row_cfg, N);
            check("rst_col_cfg", sa_col_cfg, N);
        end
        rst = 1'b0;

        load_frame(2, 1, 4, 4, N); feed_frame(-1);   // identity
        load_frame(0, 2, 4, 4, N); feed_frame(-1);   // A=i+j, B=i*j
        load_frame(0, 0, 2, 3, N); feed_frame(-1);   // partial active region
        load_frame(1, 0, 0, 7, N); feed_frame(-1);   // toggled valid, clamped cfg
        load_frame(2, 0, 4, 4, N); feed_frame(2);    // reset during FEED
        load_frame(0, 0, 4, 4, N); feed_frame(-1);
        load_frame(2, 0, 3, 3, 2);                   // reset during LOAD
        load_frame(0, 0, 3, 1, N); feed_frame(-1);
        for (int i = 0; i < 6; i++) begin
            load_frame(int'($urandom_range(0, 2)), 0,
                       int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), N);
            feed_frame(-1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
